axis_drr_scheduler: RTL and testbench

//  Deficit-round-robin egress scheduler for NUM_QUEUES packet FIFOs (axis_fifo instances).
//  - Picks which queue may emit its head packet, using per-queue byte quanta.
//  - Muxes the chosen queue's AXI-Stream onto a single master port.
//  - Sits between the per-queue FIFO bank and the egress MAC/shaper.
//  - Only whole packets are forwarded; a packet is never interleaved with another.

---
 rtl/axis_drr_scheduler_pkg.sv | 26 ++
 rtl/axis_drr_scheduler_if.sv | 20 ++
 rtl/axis_mux_n.sv | 37 +++
 rtl/axis_drr_scheduler.sv | 160 ++++++++++++++++
 tb/tb_axis_drr_scheduler.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_drr_scheduler_pkg.sv
// Shared definitions for the deficit-round-robin egress scheduler.
//   - scheduler state encoding
//   - default queue count and the matching queue index width
//   - saturating adder used for deficit replenishment
package axis_sched_pkg;

   localparam int DEFAULT_NUM_QUEUES = 4;
   localparam int QUEUE_IDX_WIDTH    = $clog2(DEFAULT_NUM_QUEUES);

   typedef enum logic {
      ST_SCAN = 1'b0,
      ST_SEND = 1'b1
   } sched_state_e;

   // a + b clamped to 2**width-1; operands are zero-extended into 32 bits
   function automatic logic [31:0] sat_add(input logic [31:0]  a,
                                           input logic [31:0]  b,
                                           input int unsigned  width);
      logic [32:0] sum;
      logic [32:0] max_val;
      sum     = {1'b0, a} + {1'b0, b};
      max_val = (33'd1 << width) - 33'd1;
      return (sum > max_val) ? max_val[31:0] : sum[31:0];
   endfunction

endpackage

// File: rtl/axis_drr_scheduler_if.sv
// AXI-Stream bundle carrying LANES parallel streams side by side.
// Lane l occupies tdata[l*DATA_WIDTH +: DATA_WIDTH] / tkeep[l*KEEP_WIDTH +: KEEP_WIDTH].
//   master : drives tvalid/tdata/tkeep/tlast, samples tready
//   slave  : samples tvalid/tdata/tkeep/tlast, drives tready
interface axis_drr_scheduler_if #(
   parameter int LANES      = 1,
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
) ();

   logic [LANES-1:0]            tvalid;
   logic [LANES-1:0]            tready;
   logic [LANES-1:0]            tlast;
   logic [LANES*DATA_WIDTH-1:0] tdata;
   logic [LANES*KEEP_WIDTH-1:0] tkeep;

   modport master (output tvalid, tdata, tkeep, tlast, input tready);
   modport slave  (input tvalid, tdata, tkeep, tlast, output tready);

endinterface

// File: rtl/axis_mux_n.sv
// Combinational N:1 AXI-Stream selector (valid/data/keep/last).
//   sel_i    : lane index to forward
//   *_i      : N lanes packed side by side
//   *_o      : selected lane; all zero if sel_i is out of range
module axis_mux_n #(
   parameter int N  = 4,
   parameter int DW = 64,
   parameter int KW = DW / 8,
   parameter int SW = $clog2(N)
) (
   input  logic [SW-1:0]   sel_i,
   input  logic [N-1:0]    valid_i,
   input  logic [N*DW-1:0] data_i,
   input  logic [N*KW-1:0] keep_i,
   input  logic [N-1:0]    last_i,
   output logic            valid_o,
   output logic [DW-1:0]   data_o,
   output logic [KW-1:0]   keep_o,
   output logic            last_o
);

   always_comb begin
      valid_o = 1'b0;
      data_o  = '0;
      keep_o  = '0;
      last_o  = 1'b0;
      for (int q = 0; q < N; q++) begin
         if (sel_i == SW'(q)) begin
            valid_o = valid_i[q];
            data_o  = data_i[q*DW +: DW];
            keep_o  = keep_i[q*KW +: KW];
            last_o  = last_i[q];
         end
      end
   end

endmodule

// File: rtl/axis_drr_scheduler.sv
// Deficit-round-robin egress scheduler. Chooses which per-queue FIFO may emit
// its head packet and forwards that whole packet onto one AXI-Stream master.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   s_axis (slave)      : NUM_QUEUES ingress lanes from the FIFO bank
//   s_packet_length_i   : head packet length in bytes per queue, valid with tvalid
//   quantum_i           : per-queue byte quantum, quasi-static
//   m_axis (master)     : single egress lane towards the MAC/shaper
//   cur_queue_o         : queue currently pointed to / served
//   busy_o              : a packet transfer is in progress
//
// state | meaning
// ------+-------------------------------------------------------------
// SCAN  | evaluate queue ptr: replenish, start a packet, or move on
// SEND  | pass queue ptr straight through until its tlast is accepted
module axis_drr_scheduler
   import axis_sched_pkg::*;
#(
   parameter int NUM_QUEUES        = DEFAULT_NUM_QUEUES,
   parameter int DATA_WIDTH        = 64,
   parameter int KEEP_WIDTH        = DATA_WIDTH / 8,
   parameter int PACKET_SIZE_WIDTH = 11,
   parameter int QUANTUM_WIDTH     = 12,
   parameter int DEFICIT_WIDTH     = 13
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   axis_drr_scheduler_if.slave                     s_axis,
   input  logic [NUM_QUEUES*PACKET_SIZE_WIDTH-1:0] s_packet_length_i,
   input  logic [NUM_QUEUES*QUANTUM_WIDTH-1:0]     quantum_i,
   axis_drr_scheduler_if.master                    m_axis,
   output logic [$clog2(NUM_QUEUES)-1:0]           cur_queue_o,
   output logic                                    busy_o
);

   localparam int QIW = $clog2(NUM_QUEUES);
   localparam logic [QIW-1:0] LAST_Q = QIW'(NUM_QUEUES - 1);

   sched_state_e             state_q, state_d;
   logic [QIW-1:0]           ptr_q, ptr_d;
   logic                     new_turn_q, new_turn_d;
   logic [DEFICIT_WIDTH-1:0] deficit_q [NUM_QUEUES];
   logic [DEFICIT_WIDTH-1:0] deficit_d [NUM_QUEUES];

   logic [DEFICIT_WIDTH-1:0] head_len;
   logic [DEFICIT_WIDTH-1:0] head_quantum;
   logic [DEFICIT_WIDTH-1:0] cur_deficit;
   logic [QIW-1:0]           next_ptr;

   logic                     mux_valid;
   logic [DATA_WIDTH-1:0]    mux_data;
   logic [KEEP_WIDTH-1:0]    mux_keep;
   logic                     mux_last;
   logic                     send_active;
   logic                     last_accepted;

   axis_mux_n #(
      .N  (NUM_QUEUES),
      .DW (DATA_WIDTH),
      .KW (KEEP_WIDTH),
      .SW (QIW)
   ) u_mux (
      .sel_i   (ptr_q),
      .valid_i (s_axis.tvalid),
      .data_i  (s_axis.tdata),
      .keep_i  (s_axis.tkeep),
      .last_i  (s_axis.tlast),
      .valid_o (mux_valid),
      .data_o  (mux_data),
      .keep_o  (mux_keep),
      .last_o  (mux_last)
   );

   // Length and quantum are zero-extended so the deficit compare is unsigned
   always_comb begin
      head_len     = '0;
      head_quantum = '0;
      cur_deficit  = '0;
      for (int q = 0; q < NUM_QUEUES; q++) begin
         if (ptr_q == QIW'(q)) begin
            head_len     = DEFICIT_WIDTH'(s_packet_length_i[q*PACKET_SIZE_WIDTH +: PACKET_SIZE_WIDTH]);
            head_quantum = DEFICIT_WIDTH'(quantum_i[q*QUANTUM_WIDTH +: QUANTUM_WIDTH]);
            cur_deficit  = deficit_q[q];
         end
      end
   end

   assign next_ptr      = (ptr_q == LAST_Q) ? '0 : ptr_q + QIW'(1);
   assign send_active   = (state_q == ST_SEND);
   assign last_accepted = send_active & mux_valid & m_axis.tready[0] & mux_last;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      new_turn_d = new_turn_q;
      deficit_d  = deficit_q;
      case (state_q)
         ST_SCAN: begin
            if (!mux_valid) begin
               // an idle queue forfeits any credit it built up
               deficit_d[ptr_q] = '0;
               ptr_d            = next_ptr;
               new_turn_d       = 1'b1;
            end else if (new_turn_q) begin
               deficit_d[ptr_q] = DEFICIT_WIDTH'(sat_add(32'(cur_deficit), 32'(head_quantum),
                                                         DEFICIT_WIDTH));
               new_turn_d       = 1'b0;
            end else if (head_len <= cur_deficit) begin
               deficit_d[ptr_q] = cur_deficit - head_len;
               state_d          = ST_SEND;
            end else begin
               ptr_d      = next_ptr;
               new_turn_d = 1'b1;
            end
         end
         ST_SEND: begin
            // new_turn stays clear so the queue keeps its turn for the next head
            if (last_accepted) begin
               state_d = ST_SCAN;
            end
         end
         default: state_d = ST_SCAN;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_SCAN;
         ptr_q      <= '0;
         new_turn_q <= 1'b1;
         for (int q = 0; q < NUM_QUEUES; q++) begin
            deficit_q[q] <= '0;
         end
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         new_turn_q <= new_turn_d;
         deficit_q  <= deficit_d;
      end
   end

   // Zero-latency pass-through of the served queue; everything idle in SCAN
   always_comb begin
      m_axis.tvalid = '0;
      m_axis.tdata  = '0;
      m_axis.tkeep  = '0;
      m_axis.tlast  = '0;
      s_axis.tready = '0;
      if (send_active) begin
         m_axis.tvalid[0]     = mux_valid;
         m_axis.tdata         = mux_data;
         m_axis.tkeep         = mux_keep;
         m_axis.tlast[0]      = mux_last;
         s_axis.tready[ptr_q] = m_axis.tready[0];
      end
   end

   assign cur_queue_o = ptr_q;
   assign busy_o      = send_active;

endmodule

// File: tb/tb_axis_drr_scheduler.sv
module tb_axis_drr_scheduler;

   localparam int NQ  = 4;
   localparam int DW  = 64;
   localparam int KW  = 8;
   localparam int PSW = 11;
   localparam int QW  = 12;
   localparam int DFW = 13;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic [NQ*PSW-1:0] pkt_len_bus = '0;
   logic [NQ*QW-1:0]  quantum_bus = '0;
   logic [1:0]        cur_queue;
   logic              busy;

   axis_drr_scheduler_if #(.LANES(NQ), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s_if ();
   axis_drr_scheduler_if #(.LANES(1),  .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) m_if ();

   axis_drr_scheduler #(
      .NUM_QUEUES        (NQ),
      .DATA_WIDTH        (DW),
      .KEEP_WIDTH        (KW),
      .PACKET_SIZE_WIDTH (PSW),
      .QUANTUM_WIDTH     (QW),
      .DEFICIT_WIDTH     (DFW)
   ) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .s_axis            (s_if.slave),
      .s_packet_length_i (pkt_len_bus),
      .quantum_i         (quantum_bus),
      .m_axis            (m_if.master),
      .cur_queue_o       (cur_queue),
      .busy_o            (busy)
   );

   initial forever #5 clk_i = ~clk_i;

   typedef struct {int len; int seq;} pkt_t;
   typedef struct {logic [DW-1:0] data; logic [KW-1:0] keep; logic last;} beat_t;

   pkt_t  src_q [NQ][$];
   pkt_t  ld_q  [NQ][$];
   int    beat_idx [NQ];
   beat_t exp_q [$];
   int    exp_def [$];

   int errors = 0;
   int checks = 0;
   int seq_cnt = 0;
   int bp_mode = 0;
   bit watch_en = 0;
   int watch_idx = 0;
   int prev_def = 0;
   int other_ready_viol = 0;
   bit wrap_seen = 0;
   int prev_cur = 0;
   bit side_def_nonzero = 0;
   int bytes_by_q [NQ];

   function automatic int nbeats(int len);
      return (len + 7) / 8;
   endfunction

   function automatic logic [DW-1:0] beat_data(int q, int seq, int b, int len);
      return {8'(q), 8'(seq), 16'(b), 32'(len)};
   endfunction

   function automatic logic [KW-1:0] beat_keep(int len, int b);
      int rem;
      rem = len - 8 * b;
      if (rem >= 8) return '1;
      return KW'((1 << rem) - 1);
   endfunction

   function automatic int def_of(int q);
      case (q)
         0: return int'(dut.deficit_q[0]);
         1: return int'(dut.deficit_q[1]);
         2: return int'(dut.deficit_q[2]);
         default: return int'(dut.deficit_q[3]);
      endcase
   endfunction

   task automatic drive_sources();
      pkt_t p;
      for (int q = 0; q < NQ; q++) begin
         if (src_q[q].size() > 0) begin
            p = src_q[q][0];
            s_if.tvalid[q]            = 1'b1;
            s_if.tdata[q*DW +: DW]    = beat_data(q, p.seq, beat_idx[q], p.len);
            s_if.tkeep[q*KW +: KW]    = beat_keep(p.len, beat_idx[q]);
            s_if.tlast[q]             = (beat_idx[q] == nbeats(p.len) - 1);
            pkt_len_bus[q*PSW +: PSW] = PSW'(p.len);
         end else begin
            s_if.tvalid[q]            = 1'b0;
            s_if.tdata[q*DW +: DW]    = '0;
            s_if.tkeep[q*KW +: KW]    = '0;
            s_if.tlast[q]             = 1'b0;
            pkt_len_bus[q*PSW +: PSW] = '0;
         end
      end
   endtask

   task automatic add_pkt(input int q, input int len);
      pkt_t p;
      p.len = len;
      p.seq = seq_cnt;
      seq_cnt = seq_cnt + 1;
      src_q[q].push_back(p);
      ld_q[q].push_back(p);
   endtask

   // next loaded packet of queue q is expected next on the egress
   task automatic expect_next(input int q);
      pkt_t  p;
      beat_t e;
      p = ld_q[q].pop_front();
      for (int b = 0; b < nbeats(p.len); b++) begin
         e.data = beat_data(q, p.seq, b, p.len);
         e.keep = beat_keep(p.len, b);
         e.last = (b == nbeats(p.len) - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic set_quanta(input int q0, input int q1, input int q2, input int q3);
      quantum_bus = {QW'(q3), QW'(q2), QW'(q1), QW'(q0)};
   endtask

   task automatic flush();
      for (int q = 0; q < NQ; q++) begin
         src_q[q].delete();
         ld_q[q].delete();
         beat_idx[q] = 0;
         bytes_by_q[q] = 0;
      end
      exp_q.delete();
      drive_sources();
   endtask

   task automatic start_test();
      rst_i = 1'b1;
      flush();
      watch_en = 0;
      exp_def.delete();
      prev_def = 0;
      bp_mode = 0;
      m_if.tready = 1'b1;
      repeat (2) @(posedge clk_i);
   endtask

   task automatic release_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d beats outstanding after %0d cycles, want 0", name, exp_q.size(), n);
      end
      repeat (12) @(negedge clk_i);
   endtask

   // source FIFO model and egress ready pattern; handshakes sampled mid-cycle
   initial begin : src_drv
      logic [NQ-1:0] hs;
      forever begin
         @(negedge clk_i);
         hs = s_if.tvalid & s_if.tready;
         @(posedge clk_i);
         #1;
         if (!rst_i) begin
            for (int q = 0; q < NQ; q++) begin
               if (hs[q] && src_q[q].size() > 0) begin
                  if (beat_idx[q] == nbeats(src_q[q][0].len) - 1) begin
                     void'(src_q[q].pop_front());
                     beat_idx[q] = 0;
                  end else begin
                     beat_idx[q] = beat_idx[q] + 1;
                  end
               end
            end
         end
         case (bp_mode)
            1: m_if.tready = ~m_if.tready;
            2: m_if.tready = 1'b0;
            default: m_if.tready = 1'b1;
         endcase
         drive_sources();
      end
   end

   initial begin : monitor
      beat_t e;
      int    d;
      int    qid;
      forever begin
         @(negedge clk_i);
         if (!rst_i) begin
            if (m_if.tvalid[0] && m_if.tready[0]) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL egress_beat: unexpected beat data=%h, want no beat", m_if.tdata);
               end else begin
                  e = exp_q.pop_front();
                  if ({m_if.tdata, m_if.tkeep, m_if.tlast} !== {e.data, e.keep, e.last}) begin
                     errors++;
                     $display("FAIL egress_beat: got data=%h keep=%h last=%b, want data=%h keep=%h last=%b",
                              m_if.tdata, m_if.tkeep, m_if.tlast, e.data, e.keep, e.last);
                  end
               end
               qid = int'(m_if.tdata[63:56]);
               if (qid < NQ) bytes_by_q[qid] += $countones(m_if.tkeep);
            end
            for (int q = 0; q < NQ; q++) begin
               if (q != int'(cur_queue) && s_if.tready[q]) other_ready_viol++;
            end
            if (prev_cur == 3 && cur_queue == 2'd0) wrap_seen = 1;
            prev_cur = int'(cur_queue);
            if (def_of(1) != 0 || def_of(2) != 0) side_def_nonzero = 1;
            if (watch_en) begin
               d = def_of(watch_idx);
               if (d != prev_def) begin
                  checks++;
                  if (exp_def.size() == 0) begin
                     errors++;
                     $display("FAIL deficit_q%0d: unexpected change to %0d", watch_idx, d);
                  end else if (d != exp_def[0]) begin
                     errors++;
                     $display("FAIL deficit_q%0d: got %0d, want %0d", watch_idx, d, exp_def[0]);
                     void'(exp_def.pop_front());
                  end else begin
                     void'(exp_def.pop_front());
                  end
                  prev_def = d;
               end
            end
         end
      end
   end

   task automatic test_reset();
      int n;
      start_test();
      set_quanta(1500, 1500, 1500, 1500);
      add_pkt(0, 72);
      bp_mode = 2;
      m_if.tready = 1'b0;
      drive_sources();
      @(negedge clk_i);
      checks++;
      if ({m_if.tvalid, m_if.tkeep, m_if.tlast, busy, cur_queue, s_if.tready} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got tvalid=%b keep=%h last=%b busy=%b cur=%0d tready=%b, want all 0",
                  m_if.tvalid, m_if.tkeep, m_if.tlast, busy, cur_queue, s_if.tready);
      end
      release_reset();
      n = 0;
      while (!busy && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_enter_send: busy=%b after %0d cycles, want 1", busy, n);
      end
      checks++;
      if (m_if.tvalid[0] !== 1'b1 || s_if.tready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_stalled_send: tvalid=%b tready=%b, want 1 and 0000", m_if.tvalid, s_if.tready);
      end
      checks++;
      if (def_of(0) != 1428) begin
         errors++;
         $display("FAIL reset_pre_deficit: got %0d, want 1428", def_of(0));
      end
      #2;
      rst_i = 1'b1;
      #1;
      checks++;
      if (m_if.tvalid[0] !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_abort: tvalid=%b busy=%b, want 0 0", m_if.tvalid, busy);
      end
      checks++;
      if (m_if.tkeep !== '0 || m_if.tlast !== 1'b0 || s_if.tready !== 4'b0000 || cur_queue !== 2'd0) begin
         errors++;
         $display("FAIL reset_abort_outputs: keep=%h last=%b tready=%b cur=%0d, want 0",
                  m_if.tkeep, m_if.tlast, s_if.tready, cur_queue);
      end
      checks++;
      if (def_of(0) != 0 || def_of(1) != 0 || def_of(2) != 0 || def_of(3) != 0) begin
         errors++;
         $display("FAIL reset_deficits: got %0d %0d %0d %0d, want 0 0 0 0",
                  def_of(0), def_of(1), def_of(2), def_of(3));
      end
      flush();
      release_reset();
      #1;
      checks++;
      if (cur_queue !== 2'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: cur=%0d busy=%b, want 0 0", cur_queue, busy);
      end
      repeat (4) @(negedge clk_i);
   endtask

   task automatic test_single_queue();
      start_test();
      set_quanta(1500, 1500, 1500, 1500);
      for (int i = 0; i < 3; i++) begin
         add_pkt(0, 64);
         expect_next(0);
      end
      drive_sources();
      watch_idx = 0;
      exp_def = '{1500, 1436, 1372, 1308, 0};
      watch_en = 1;
      release_reset();
      wait_drain("single_queue", 200);
      checks++;
      if (exp_def.size() != 0) begin
         errors++;
         $display("FAIL single_queue_deficit_seq: %0d updates missing, want 0", exp_def.size());
      end
      watch_en = 0;
   endtask

   task automatic test_ratio();
      int order [8];
      start_test();
      set_quanta(1500, 500, 1500, 1500);
      for (int i = 0; i < 6; i++) add_pkt(0, 1000);
      for (int i = 0; i < 2; i++) add_pkt(1, 1000);
      order = '{0, 0, 0, 1, 0, 0, 0, 1};
      foreach (order[i]) expect_next(order[i]);
      drive_sources();
      release_reset();
      wait_drain("ratio", 2500);
      checks++;
      if (bytes_by_q[0] != 6000 || bytes_by_q[1] != 2000) begin
         errors++;
         $display("FAIL ratio_bytes: got q0=%0d q1=%0d, want 6000 2000", bytes_by_q[0], bytes_by_q[1]);
      end
   endtask

   task automatic test_skip_turns();
      start_test();
      set_quanta(1500, 300, 1500, 1500);
      add_pkt(1, 1000);
      expect_next(1);
      drive_sources();
      watch_idx = 1;
      exp_def = '{300, 600, 900, 1200, 200, 0};
      watch_en = 1;
      release_reset();
      wait_drain("skip_turns", 400);
      checks++;
      if (exp_def.size() != 0) begin
         errors++;
         $display("FAIL skip_turns_deficit_seq: %0d updates missing, want 0", exp_def.size());
      end
      watch_en = 0;
   endtask

   task automatic test_backpressure();
      start_test();
      set_quanta(1500, 1500, 1500, 1500);
      add_pkt(0, 70);
      add_pkt(2, 16);
      expect_next(0);
      expect_next(2);
      drive_sources();
      bp_mode = 1;
      other_ready_viol = 0;
      release_reset();
      wait_drain("backpressure", 200);
      checks++;
      if (other_ready_viol != 0) begin
         errors++;
         $display("FAIL backpressure_other_tready: got %0d cycles, want 0", other_ready_viol);
      end
      checks++;
      if (bytes_by_q[0] != 70 || bytes_by_q[2] != 16) begin
         errors++;
         $display("FAIL backpressure_bytes: got q0=%0d q2=%0d, want 70 16", bytes_by_q[0], bytes_by_q[2]);
      end
      bp_mode = 0;
   endtask

   task automatic test_wrap();
      start_test();
      set_quanta(16, 1500, 1500, 16);
      for (int i = 0; i < 3; i++) begin
         add_pkt(0, 16);
         add_pkt(3, 16);
      end
      for (int i = 0; i < 3; i++) begin
         expect_next(0);
         expect_next(3);
      end
      drive_sources();
      wrap_seen = 0;
      side_def_nonzero = 0;
      prev_cur = 0;
      release_reset();
      wait_drain("wrap", 300);
      checks++;
      if (wrap_seen !== 1'b1) begin
         errors++;
         $display("FAIL wrap_ptr: wrap 3->0 seen=%b, want 1", wrap_seen);
      end
      checks++;
      if (side_def_nonzero !== 1'b0) begin
         errors++;
         $display("FAIL wrap_idle_deficits: q1/q2 nonzero seen=%b, want 0", side_def_nonzero);
      end
   endtask

   task automatic test_zero_quantum();
      start_test();
      set_quanta(1500, 1500, 0, 1500);
      add_pkt(2, 8);
      add_pkt(0, 8);
      expect_next(0);
      drive_sources();
      release_reset();
      wait_drain("zero_quantum", 100);
      repeat (40) @(negedge clk_i);
      checks++;
      if (src_q[2].size() != 1 || def_of(2) != 0) begin
         errors++;
         $display("FAIL zero_quantum_q2: pending=%0d deficit=%0d, want 1 0", src_q[2].size(), def_of(2));
      end
   endtask

   initial begin : timeout
      #800000;
      $display("FAIL timeout: simulation time limit reached, want completion");
      $fatal(1, "timeout");
   end

   initial begin : main
      m_if.tready = 1'b1;
      drive_sources();
      test_reset();
      test_single_queue();
      test_ratio();
      test_skip_turns();
      test_backpressure();
      test_wrap();
      test_zero_quantum();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
